alu_operand_fifo: RTL and testbench

Operand staging buffer that sits directly upstream of the registered ALU stage. It accepts operand pairs from a producer through a write-enable/full interface, stores up to DEPTH pairs in order, and presents one pair per read on registered `in0`/`in1` outputs. These outputs wire straight to the ALU's operand inputs. Overflow and underflow attempts are flagged and stay set until cleared, so the bench can catch producer or consumer misuse.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_fifo_ptr.sv | 26 ++
 rtl/alu_operand_fifo.sv | 129 ++++++++++++
 tb/tb_alu_operand_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and operand-pair type for the ALU operand path.
package alu_pkg;

  localparam int ALU_N     = 4;
  localparam int ALU_DEPTH = 4;
  localparam int PTR_W     = $clog2(ALU_DEPTH);

  // One operand pair as seen by the ALU stage; op0 sits in the upper half.
  typedef struct packed {
    logic [ALU_N-1:0] op0;
    logic [ALU_N-1:0] op1;
  } operand_pair_t;

  // Pack two operands into the pair layout used by storage and benches.
  function automatic operand_pair_t make_pair(input logic [ALU_N-1:0] a,
                                              input logic [ALU_N-1:0] b);
    operand_pair_t p;
    p.op0 = a;
    p.op1 = b;
    return p;
  endfunction

endpackage

// File: rtl/alu_fifo_ptr.sv
// Modulo-DEPTH pointer register with increment enable and synchronous clear.
module alu_fifo_ptr
  import alu_pkg::*;
#(
  parameter int DEPTH = ALU_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // DEPTH is a power of two, so natural PW-bit rollover is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/alu_operand_fifo.sv
// Operand staging FIFO feeding the registered ALU stage.
//
// Handshake: a write is accepted on a rising edge when wr_en && !full, a read
// when rd_en && !empty; full/empty are the registered pre-edge values. A
// rejected write sets ovf, a rejected read sets udf; both flags are sticky
// until flush. flush (below reset, above everything else) empties the FIFO,
// clears the flags and out_valid, ignores same-cycle wr_en/rd_en, and leaves
// in0/in1 untouched. out_valid pulses for each accepted read.
module alu_operand_fifo
  import alu_pkg::*;
#(
  parameter int N     = ALU_N,
  parameter int DEPTH = ALU_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [N-1:0]             wr_in0,
  input  logic [N-1:0]             wr_in1,
  input  logic                     rd_en,
  output logic [N-1:0]             in0,
  output logic [N-1:0]             in1,
  output logic                     out_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [2*N-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [2*N-1:0] rd_pair;
  logic           wr_acc;
  logic           rd_acc;
  logic [CW-1:0]  count_nxt;

  // Accepts are judged on registered full/empty, so simultaneous ops at the
  // boundaries resolve on the pre-edge occupancy.
  assign wr_acc  = !flush && wr_en && !full;
  assign rd_acc  = !flush && rd_en && !empty;
  assign rd_pair = mem[rd_ptr];

  alu_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  alu_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  // Next occupancy; count alone drives full/empty so wrap needs no tracking.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Occupancy and status registers, kept mutually consistent every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  // Sticky misuse flags; only flush or reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (flush) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full)  ovf <= 1'b1;
      if (rd_en && empty) udf <= 1'b1;
    end
  end

  // Pair storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= {wr_in0, wr_in1};
    end
  end

  // Registered operand outputs; they move only on an accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in0       <= '0;
      in1       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_acc;
      if (rd_acc) begin
        in0 <= rd_pair[2*N-1:N];
        in1 <= rd_pair[N-1:0];
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_fifo.sv
// Directed bench for alu_operand_fifo with a small downstream ALU model.
module tb_alu_operand_fifo;
  import alu_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         wr_en;
  logic [N-1:0] wr_in0;
  logic [N-1:0] wr_in1;
  logic         rd_en;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic         out_valid;
  logic         full;
  logic         empty;
  logic [2:0]   count;
  logic         ovf;
  logic         udf;

  logic [N-1:0]   alu_q;
  logic [2*N-1:0] exp_q[$];
  int n_checks;
  int n_pass;

  alu_operand_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_in0    (wr_in0),
    .wr_in1    (wr_in1),
    .rd_en     (rd_en),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .udf       (udf)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream registered ALU stand-in: adds the two operands.
  always @(posedge clk) alu_q <= in0 + in1;

  // Advance one edge and settle just past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; wr_in0 = '0; wr_in1 = '0;
  endtask

  task automatic do_flush();
    idle_inputs(); flush = 1'b1; cyc(); flush = 1'b0;
  endtask

  task automatic drv_write(input logic [N-1:0] a, input logic [N-1:0] b);
    wr_en = 1'b1; wr_in0 = a; wr_in1 = b; cyc(); wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; wr_en = 1'b1; rd_en = 1'b1; wr_in0 = 4'd5; wr_in1 = 4'd6;
    repeat (3) cyc();
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_checks++; if ({in0, in1} !== 8'h00) $display("FAIL reset_operands got %h exp 00", {in0, in1}); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if ({ovf, udf, full} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {ovf, udf, full}); else n_pass++;
    idle_inputs();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_order_overflow();
    logic [N-1:0] a_tab [4];
    logic [N-1:0] b_tab [4];
    logic [N-1:0] s_tab [4];
    a_tab = '{4'd2, 4'd3, 4'd7, 4'd15};
    b_tab = '{4'd4, 4'd5, 4'd1, 4'd0};
    s_tab = '{4'd6, 4'd8, 4'd8, 4'd15};
    for (int i = 0; i < 4; i++) begin
      drv_write(a_tab[i], b_tab[i]);
      n_checks++; if (count !== 3'(i + 1)) $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); else n_pass++;
    end
    n_checks++; if ({full, empty} !== 2'b10) $display("FAIL fill_full_empty got %b exp 10", {full, empty}); else n_pass++;
    // overflow attempt
    drv_write(4'd9, 4'd9);
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set got %b exp 1", ovf); else n_pass++;
    n_checks++; if (count !== 3'd4) $display("FAIL ovf_count got %0d exp 4", count); else n_pass++;
    // back-to-back reads
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if ({in0, in1, out_valid} !== {a_tab[i], b_tab[i], 1'b1})
        $display("FAIL read[%0d] got %0d/%0d v%b exp %0d/%0d v1", i, in0, in1, out_valid, a_tab[i], b_tab[i]); else n_pass++;
      if (i > 0) begin
        n_checks++; if (alu_q !== s_tab[i-1]) $display("FAIL alu[%0d] got %0d exp %0d", i - 1, alu_q, s_tab[i-1]); else n_pass++;
      end
    end
    rd_en = 1'b0;
    cyc();
    n_checks++; if (alu_q !== s_tab[3]) $display("FAIL alu[3] got %0d exp %0d", alu_q, s_tab[3]); else n_pass++;
    n_checks++; if ({out_valid, empty, count} !== {1'b0, 1'b1, 3'd0}) $display("FAIL drained got v%b e%b c%0d exp v0 e1 c0", out_valid, empty, count); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf); else n_pass++;
  endtask

  task automatic test_underflow();
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    n_checks++; if (udf !== 1'b1) $display("FAIL udf_set got %b exp 1", udf); else n_pass++;
    n_checks++; if ({in0, in1, out_valid} !== {4'd15, 4'd0, 1'b0}) $display("FAIL udf_hold got %0d/%0d v%b exp 15/0 v0", in0, in1, out_valid); else n_pass++;
    do_flush();
    n_checks++; if ({ovf, udf} !== 2'b00) $display("FAIL flush_flags got %b exp 00", {ovf, udf}); else n_pass++;
    n_checks++; if ({in0, in1} !== {4'd15, 4'd0}) $display("FAIL flush_hold got %0d/%0d exp 15/0", in0, in1); else n_pass++;
  endtask

  task automatic test_flush_ignores();
    drv_write(4'd1, 4'd2);
    drv_write(4'd3, 4'd4);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_in0 = 4'd8; wr_in1 = 4'd8;
    cyc();
    idle_inputs();
    n_checks++; if ({count, empty, full} !== {3'd0, 1'b1, 1'b0}) $display("FAIL flush_count got c%0d e%b f%b exp c0 e1 f0", count, empty, full); else n_pass++;
    n_checks++; if ({ovf, udf, out_valid} !== 3'b000) $display("FAIL flush_noflags got %b exp 000", {ovf, udf, out_valid}); else n_pass++;
    n_checks++; if ({in0, in1} !== {4'd15, 4'd0}) $display("FAIL flush_noread got %0d/%0d exp 15/0", in0, in1); else n_pass++;
  endtask

  task automatic test_simultaneous();
    // from full: read wins, write dropped
    drv_write(4'd1, 4'd1); drv_write(4'd2, 4'd2); drv_write(4'd3, 4'd3); drv_write(4'd4, 4'd4);
    wr_en = 1'b1; rd_en = 1'b1; wr_in0 = 4'd9; wr_in1 = 4'd9; cyc(); idle_inputs();
    n_checks++; if ({count, ovf, full} !== {3'd3, 1'b1, 1'b0}) $display("FAIL sim_full got c%0d o%b f%b exp c3 o1 f0", count, ovf, full); else n_pass++;
    n_checks++; if ({in0, in1, out_valid} !== {4'd1, 4'd1, 1'b1}) $display("FAIL sim_full_data got %0d/%0d v%b exp 1/1 v1", in0, in1, out_valid); else n_pass++;
    do_flush();
    // from empty: write wins, read rejected
    wr_en = 1'b1; rd_en = 1'b1; wr_in0 = 4'd6; wr_in1 = 4'd7; cyc(); idle_inputs();
    n_checks++; if ({count, udf, empty, out_valid} !== {3'd1, 1'b1, 1'b0, 1'b0}) $display("FAIL sim_empty got c%0d u%b e%b v%b exp c1 u1 e0 v0", count, udf, empty, out_valid); else n_pass++;
    do_flush();
    // from count 2: both accepted
    drv_write(4'd10, 4'd11); drv_write(4'd12, 4'd13);
    wr_en = 1'b1; rd_en = 1'b1; wr_in0 = 4'd14; wr_in1 = 4'd5; cyc(); idle_inputs();
    n_checks++; if ({count, ovf, udf} !== {3'd2, 1'b0, 1'b0}) $display("FAIL sim_mid got c%0d o%b u%b exp c2 o0 u0", count, ovf, udf); else n_pass++;
    n_checks++; if ({in0, in1, out_valid} !== {4'd10, 4'd11, 1'b1}) $display("FAIL sim_mid_data got %0d/%0d v%b exp 10/11 v1", in0, in1, out_valid); else n_pass++;
    // drain the two remaining to confirm order across the simultaneous op
    rd_en = 1'b1; cyc();
    n_checks++; if ({in0, in1} !== {4'd12, 4'd13}) $display("FAIL sim_mid_drain0 got %0d/%0d exp 12/13", in0, in1); else n_pass++;
    cyc(); rd_en = 1'b0;
    n_checks++; if ({in0, in1, empty} !== {4'd14, 4'd5, 1'b1}) $display("FAIL sim_mid_drain1 got %0d/%0d e%b exp 14/5 e1", in0, in1, empty); else n_pass++;
    do_flush();
  endtask

  task automatic test_wrap();
    operand_pair_t p;
    int cnt;
    int writes;
    cnt = 0;
    writes = 0;
    exp_q.delete();
    while (writes < 10 || exp_q.size() > 0) begin
      idle_inputs();
      if (writes < 10 && cnt < DEPTH) begin
        wr_en = 1'b1;
        wr_in0 = N'($urandom_range(0, 15));
        wr_in1 = N'($urandom_range(0, 15));
      end
      if (cnt > 0 && (writes >= 10 || cnt == DEPTH || $urandom_range(0, 1) == 1)) rd_en = 1'b1;
      if (wr_en) begin
        p = make_pair(wr_in0, wr_in1);
        exp_q.push_back(p);
        writes++;
        cnt++;
      end
      cyc();
      if (rd_en) begin
        p = exp_q.pop_front();
        cnt--;
        n_checks++; if ({in0, in1, out_valid} !== {p.op0, p.op1, 1'b1})
          $display("FAIL wrap_read got %0d/%0d v%b exp %0d/%0d v1", in0, in1, out_valid, p.op0, p.op1); else n_pass++;
      end
      n_checks++; if (count !== 3'(cnt)) $display("FAIL wrap_count got %0d exp %0d", count, cnt); else n_pass++;
    end
    idle_inputs();
    n_checks++; if ({ovf, udf, empty} !== 3'b001) $display("FAIL wrap_end got %b exp 001", {ovf, udf, empty}); else n_pass++;
  endtask

  task automatic test_midop_reset();
    drv_write(4'd5, 4'd9);
    drv_write(4'd6, 4'd3);
    rd_en = 1'b1; wr_en = 1'b1; wr_in0 = 4'd1; wr_in1 = 4'd1;
    cyc();
    // asynchronous assertion between edges, with traffic still driven
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({count, empty, full} !== {3'd0, 1'b1, 1'b0}) $display("FAIL rst_async_status got c%0d e%b f%b exp c0 e1 f0", count, empty, full); else n_pass++;
    n_checks++; if ({in0, in1, out_valid} !== {4'd0, 4'd0, 1'b0}) $display("FAIL rst_async_data got %0d/%0d v%b exp 0/0 v0", in0, in1, out_valid); else n_pass++;
    idle_inputs();
    cyc();
    rst = 1'b1;
    cyc();
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    n_checks++; if ({udf, out_valid, in0} !== {1'b1, 1'b0, 4'd0}) $display("FAIL rst_discard got u%b v%b in0=%0d exp u1 v0 in0=0", udf, out_valid, in0); else n_pass++;
  endtask

  // Test sequence and final report
  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_order_overflow();
    test_underflow();
    test_flush_ignores();
    test_simultaneous();
    test_wrap();
    test_midop_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
